// File: rtl/column_game_scheduler.sv
// ============================================================================
//  Module   : column_game_scheduler
//  Purpose  : Fall timebase, round-robin spawn, keypress arbitration, score.
//             Optional miss penalty enabled by defining MISS_PENALTY_EN.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module column_game_scheduler #(
    parameter int NUM_COLS    = 4,
    parameter int TICK_DIV    = 50000000,
    parameter int SPAWN_TICKS = 3,
    parameter int SCORE_W     = 8
) (
    input  logic                  clock,
    input  logic                  reset_signal,
    input  logic                  start,
    input  logic                  key_valid,
    input  logic [7:0]            key_code,
    input  logic [NUM_COLS-1:0]   col_active,
    input  logic [NUM_COLS*8-1:0] col_letter,
    input  logic [NUM_COLS*5-1:0] col_ypos,
    input  logic [NUM_COLS-1:0]   col_game_over,
    output logic [NUM_COLS-1:0]   spawn,
    output logic                  fall_tick,
    output logic [NUM_COLS-1:0]   clear,
    output logic [SCORE_W-1:0]    score,
    output logic                  playing,
    output logic                  game_over
);

    localparam int IDX_W = (NUM_COLS > 1) ? $clog2(NUM_COLS) : 1;
    localparam int TW    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int SW    = (SPAWN_TICKS > 1) ? $clog2(SPAWN_TICKS) : 1;
    localparam logic [NUM_COLS-1:0] ONE_HOT0 = NUM_COLS'(1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        OVER = 2'd2
    } state_t;

    state_t           state;
    logic [TW-1:0]    tick_cnt;
    logic [SW-1:0]    spawn_cnt;
    logic [IDX_W-1:0] ptr;

    logic [7:0]       letter [NUM_COLS];
    logic [4:0]       ypos   [NUM_COLS];

    for (genvar g = 0; g < NUM_COLS; g++) begin : g_cols
        assign letter[g] = col_letter[8*g +: 8];
        assign ypos[g]   = col_ypos[5*g +: 5];
    end

    // Spawn target: first free column at or after the pointer, wrapping.
    int               cand;
    logic             spawn_found;
    logic [IDX_W-1:0] spawn_target;
    logic [IDX_W-1:0] next_ptr;

    always_comb begin
        cand         = 0;
        spawn_found  = 1'b0;
        spawn_target = '0;
        for (int k = 0; k < NUM_COLS; k++) begin
            cand = (int'(ptr) + k) % NUM_COLS;
            if (!spawn_found && !col_active[cand]) begin
                spawn_found  = 1'b1;
                spawn_target = IDX_W'(cand);
            end
        end
        next_ptr = (spawn_target == IDX_W'(NUM_COLS - 1)) ? '0 : spawn_target + 1'b1;
    end

    // Key winner: deepest matching letter; strict compare keeps lowest index on ties.
    logic             hit_found;
    logic [IDX_W-1:0] hit_idx;
    logic [4:0]       hit_y;

    always_comb begin
        hit_found = 1'b0;
        hit_idx   = '0;
        hit_y     = '0;
        for (int i = 0; i < NUM_COLS; i++) begin
            if (col_active[i] && (letter[i] == key_code) && (!hit_found || (ypos[i] > hit_y))) begin
                hit_found = 1'b1;
                hit_idx   = IDX_W'(i);
                hit_y     = ypos[i];
            end
        end
    end

    logic tick_wrap;
    assign tick_wrap = (tick_cnt == TW'(TICK_DIV - 1));

    always_ff @(posedge clock) begin
        if (reset_signal) begin
            state     <= IDLE;
            tick_cnt  <= '0;
            spawn_cnt <= '0;
            ptr       <= '0;
            spawn     <= '0;
            fall_tick <= 1'b0;
            clear     <= '0;
            score     <= '0;
            playing   <= 1'b0;
            game_over <= 1'b0;
        end else begin
            spawn     <= '0;
            fall_tick <= 1'b0;
            clear     <= '0;
            case (state)
                IDLE, OVER: begin
                    if (start) begin
                        state     <= RUN;
                        playing   <= 1'b1;
                        game_over <= 1'b0;
                        score     <= '0;
                        tick_cnt  <= '0;
                        spawn_cnt <= '0;
                        if (spawn_found) begin
                            spawn <= ONE_HOT0 << spawn_target;
                            ptr   <= next_ptr;
                        end
                    end
                end
                RUN: begin
                    if (|col_game_over) begin
                        state     <= OVER;
                        playing   <= 1'b0;
                        game_over <= 1'b1;
                    end else begin
                        tick_cnt <= tick_wrap ? '0 : tick_cnt + 1'b1;
                        if (tick_wrap) begin
                            fall_tick <= 1'b1;
                            if (spawn_cnt == SW'(SPAWN_TICKS - 1)) begin
                                spawn_cnt <= '0;
                                if (spawn_found) begin
                                    spawn <= ONE_HOT0 << spawn_target;
                                    ptr   <= next_ptr;
                                end
                            end else begin
                                spawn_cnt <= spawn_cnt + 1'b1;
                            end
                        end
                        if (key_valid) begin
                            if (hit_found) begin
                                clear <= ONE_HOT0 << hit_idx;
                                if (score != '1) score <= score + 1'b1;
                            end
`ifdef MISS_PENALTY_EN
                            else if (score != '0) begin
                                score <= score - 1'b1;
                            end
`else
                            else begin
                                score <= score;
                            end
`endif
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_column_game_scheduler.sv
// ============================================================================
//  Module   : tb_column_game_scheduler
//  Purpose  : Directed self-checking bench for column_game_scheduler.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module tb_column_game_scheduler;

`ifdef MISS_PENALTY_EN
    localparam bit PEN = 1'b1;
`else
    localparam bit PEN = 1'b0;
`endif

    logic        clock = 1'b0;
    logic        reset_signal;
    logic        start;
    logic        key_valid;
    logic [7:0]  key_code;
    logic [3:0]  col_active;
    logic [31:0] col_letter;
    logic [19:0] col_ypos;
    logic [3:0]  col_game_over;
    logic [3:0]  spawn;
    logic        fall_tick;
    logic [3:0]  clear;
    logic [7:0]  score;
    logic        playing;
    logic        game_over;

    int n_checks = 0;
    int n_fail   = 0;
    logic [7:0] exp_score;

    column_game_scheduler #(
        .NUM_COLS(4), .TICK_DIV(4), .SPAWN_TICKS(2), .SCORE_W(8)
    ) dut (
        .clock(clock), .reset_signal(reset_signal), .start(start),
        .key_valid(key_valid), .key_code(key_code), .col_active(col_active),
        .col_letter(col_letter), .col_ypos(col_ypos), .col_game_over(col_game_over),
        .spawn(spawn), .fall_tick(fall_tick), .clear(clear), .score(score),
        .playing(playing), .game_over(game_over)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    initial begin
        reset_signal  = 1'b1;
        start         = 1'b0;
        key_valid     = 1'b0;
        key_code      = 8'h00;
        col_active    = 4'b0000;
        col_letter    = {8'h41, 8'h00, 8'h41, 8'h42};
        col_ypos      = {5'd9, 5'd0, 5'd5, 5'd0};
        col_game_over = 4'b0000;
        exp_score     = 8'd0;
        step();
        step();
        check("rst_spawn", spawn, 0);
        check("rst_tick", fall_tick, 0);
        check("rst_clear", clear, 0);
        check("rst_score", score, 0);
        check("rst_playing", playing, 0);
        check("rst_over", game_over, 0);
        reset_signal = 1'b0;
        step();
        check("idle_spawn", spawn, 0);

        // Start: first spawn into column 0, then ticks every 4 cycles.
        start = 1'b1;
        step();
        start = 1'b0;
        check("start_spawn", spawn, 4'b0001);
        check("start_playing", playing, 1);
        for (int k = 1; k <= 8; k++) begin
            step();
            check($sformatf("tick_%0d", k), fall_tick, (k == 4 || k == 8) ? 1 : 0);
            check($sformatf("spawn_%0d", k), spawn, (k == 8) ? 4'b0010 : 4'b0000);
        end

        // Arbitration: deepest wins, then tie goes to lowest index.
        col_active = 4'b1010;
        key_valid  = 1'b1;
        key_code   = 8'h41;
        step();
        exp_score = 8'd1;
        check("hit_deep_clear", clear, 4'b1000);
        check("hit_deep_score", score, exp_score);
        col_ypos = {5'd5, 5'd0, 5'd5, 5'd0};
        step();
        exp_score = 8'd2;
        check("hit_tie_clear", clear, 4'b0010);
        check("hit_tie_score", score, exp_score);
        key_valid = 1'b0;
        step();
        check("clear_pulse", clear, 4'b0000);
        key_valid = 1'b1;
        key_code  = 8'h55;
        step();
        key_valid = 1'b0;
        if (PEN) exp_score = exp_score - 8'd1;
        check("miss_clear", clear, 4'b0000);
        check("miss_score", score, exp_score);

        // Full board at the spawn attempt: skipped, pointer stays at 2.
        col_active = 4'b1111;
        for (int k = 13; k <= 16; k++) step();
        check("full_tick", fall_tick, 1);
        check("full_spawn", spawn, 4'b0000);
        col_active = 4'b1010;
        for (int k = 17; k <= 24; k++) begin
            step();
            check($sformatf("resume_spawn_%0d", k), spawn, (k == 24) ? 4'b0100 : 4'b0000);
        end

        // Game over beats a matching key in the same cycle.
        col_game_over = 4'b0001;
        key_valid     = 1'b1;
        key_code      = 8'h41;
        step();
        col_game_over = 4'b0000;
        check("go_over", game_over, 1);
        check("go_playing", playing, 0);
        check("go_clear", clear, 4'b0000);
        check("go_score", score, exp_score);
        for (int k = 0; k < 5; k++) step();
        check("over_clear", clear, 4'b0000);
        check("over_tick", fall_tick, 0);
        check("over_spawn", spawn, 4'b0000);
        check("over_score", score, exp_score);
        key_valid = 1'b0;
        start     = 1'b1;
        step();
        start = 1'b0;
        check("restart_playing", playing, 1);
        check("restart_over", game_over, 0);
        check("restart_score", score, 0);
        check("restart_spawn", spawn, 4'b0001);

        // Saturation at all-ones.
        key_valid = 1'b1;
        key_code  = 8'h41;
        for (int k = 0; k < 255; k++) step();
        check("sat_reach", score, 8'hFF);
        step();
        check("sat_hold", score, 8'hFF);
        check("sat_clear", clear, 4'b0010);
        key_code = 8'h7E;
        step();
        check("sat_miss", score, PEN ? 8'hFE : 8'hFF);

        // Reset mid-run with a clear pending.
        key_code     = 8'h41;
        reset_signal = 1'b1;
        step();
        reset_signal = 1'b0;
        key_valid    = 1'b0;
        check("midrst_clear", clear, 4'b0000);
        check("midrst_spawn", spawn, 4'b0000);
        check("midrst_score", score, 0);
        check("midrst_playing", playing, 0);
        check("midrst_tick", fall_tick, 0);
        check("midrst_over", game_over, 0);
        step();
        check("midrst_idle", playing, 0);
        start = 1'b1;
        step();
        start = 1'b0;
        check("rerun_spawn", spawn, 4'b0001);
        check("rerun_playing", playing, 1);
        key_valid = 1'b1;
        key_code  = 8'h33;
        step();
        key_valid = 1'b0;
        check("zero_miss", score, 0);
        check("rerun_tick1", fall_tick, 0);
        step();
        step();
        check("rerun_tick3", fall_tick, 0);
        step();
        check("rerun_tick4", fall_tick, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/column_game_scheduler.md
Name: column_game_scheduler

Overview:
- Top-level sequencer for the falling-letter playfield.
- Owns the shared fall-rate timebase and decides when, and into which column, a new letter spawns.
- Arbitrates each user keypress to at most one matching column and keeps the score.
- Latches game over when any column reaches the board bottom.

Parameters:
- NUM_COLS, 4: number of column controllers managed.
- TICK_DIV, 50000000: clock cycles per fall step.
- SPAWN_TICKS, 3: fall ticks between spawn attempts (>=1).
- SCORE_W, 8: score width.

Ports:
- clock  in  1  system clock, all logic on posedge.
- reset_signal  in  1  synchronous, active-high reset.
- start  in  1  level; begins a game from IDLE/OVER.
- key_valid  in  1  one-cycle pulse, user key available.
- key_code  in  8  user key value, valid with key_valid.
- col_active  in  NUM_COLS  column i currently has a falling letter.
- col_letter  in  NUM_COLS*8  letter of column i, bits [8i+7:8i].
- col_ypos  in  NUM_COLS*5  row of column i, bits [5i+4:5i], 0 = top.
- col_game_over  in  NUM_COLS  column i hit the bottom.
- spawn  out  NUM_COLS  one-hot, one-cycle: load new letter into column i.
- fall_tick  out  1  one-cycle pulse: all columns step down.
- clear  out  NUM_COLS  one-hot, one-cycle: column i was hit, retire letter.
- score  out  SCORE_W  current score.
- playing  out  1  high in RUN.
- game_over  out  1  high in OVER.

Behaviour:
- All outputs registered. Reset values: spawn=0, fall_tick=0, clear=0, score=0, playing=0, game_over=0, state=IDLE, tick counter=0, spawn counter=0, round-robin pointer=0.
- Reset has priority over all other events and may arrive in any state, including mid-game.
- States:
  - IDLE: on start, go to RUN; clear score; spawn counter=0.
  - RUN: on any col_game_over bit, go to OVER.
  - OVER: hold; on start, go to RUN (score cleared).
- Tick counter runs only in RUN. It counts 0..TICK_DIV-1 and wraps. fall_tick=1 on the cycle after the counter equals TICK_DIV-1. It is zeroed on RUN entry.
- Spawn:
  - First spawn attempt occurs on the first cycle in RUN.
  - Subsequent attempts occur on every SPAWN_TICKS-th fall_tick.
  - Target column: first i with col_active[i]=0, searching from the pointer upward with wrap.
  - After a spawn, pointer = target+1 mod NUM_COLS.
  - If all columns are active, the attempt is skipped and the pointer is unchanged.
- Key arbitration, RUN only:
  - On key_valid, candidates are columns with col_active=1 and col_letter==key_code.
  - Winner is the candidate with the largest col_ypos; ties go to the lowest index.
  - clear[winner] pulses the next cycle (latency 1).
  - score increments, saturating at all-ones.
  - At most one clear per key.
- No candidate: score unchanged (see Optional Feature).
- key_valid outside RUN: ignored.
- Simultaneous events:
  - col_game_over and key_valid in the same cycle: game over wins; no clear, no score change.
  - Spawn and clear in the same cycle are both issued. They never target the same column, since spawn requires inactive and clear requires active.
- In OVER: spawn, clear and fall_tick are held 0; score is frozen.

Optional Feature:
- Macro: MISS_PENALTY_EN.
- Defined: key_valid in RUN with no candidate decrements score by 1, saturating at 0, with 1-cycle latency.
- Undefined: non-matching keys have no effect.

Test Plan:
- TICK_DIV=4, SPAWN_TICKS=2, all col_active=0; assert start for 1 cycle -> spawn=0001 in the first RUN cycle; fall_tick every 4 cycles; spawn=0010 on the 2nd fall_tick after that.
- Columns 1 and 3 both active with letter 8'h41, ypos 5 and 9; key_valid with 8'h41 -> clear=1000 next cycle, score 0->1. Repeat with equal ypos -> clear=0010.
- All four columns active at a spawn attempt -> spawn stays 0000 and the pointer is unchanged; then drop col_active[2] -> next attempt spawn=0100.
- col_game_over[0]=1 in the same cycle as a matching key_valid -> game_over=1, playing=0, no clear, score unchanged; then start -> RUN with score=0.
- Score at 8'hFF plus a matching key -> score stays 8'hFF. With MISS_PENALTY_EN: score=0 plus a non-matching key -> score stays 0; score=5 plus a non-matching key -> 4.
- reset_signal asserted mid-RUN with a pending clear -> next cycle all outputs are 0 and state is IDLE; start afterwards restarts with spawn=0001.
